// File: rtl/spi_pkg.sv
// spi_pkg: shared constants and strobe decode for the SPI controller/datapath pair.
// Optional feature macro used by the datapath: SPI_RX_HOLD_EN.
package spi_pkg;

    localparam int DATA_W_DEFAULT = 16;
    localparam int LEN_W          = 4;

    // One strobe per cycle. Load has priority over write, and write has priority over read.
    typedef enum logic [1:0] {
        STB_IDLE  = 2'd0,
        STB_LOAD  = 2'd1,
        STB_WRITE = 2'd2,
        STB_READ  = 2'd3
    } strobe_e;

    function automatic strobe_e decode_strobe(input logic load, input logic en, input logic oe);
        strobe_e s;
        s = STB_IDLE;
        if (load) begin
            s = STB_LOAD;
        end else if (en) begin
            s = STB_WRITE;
        end else if (oe) begin
            s = STB_READ;
        end
        return s;
    endfunction

endpackage

// File: rtl/spi_rx_hold.sv
// spi_rx_hold: received-word buffer with a level valid flag and a sticky overrun flag.
// This block is instantiated by spi_shift only when SPI_RX_HOLD_EN is defined.
module spi_rx_hold #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              done_i,
    input  logic [DATA_W-1:0] word_i,
    input  logic              rx_rd_i,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              rx_ovr_o
);

    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              ovr_q, ovr_d;

    // Accept a word when the buffer is empty or being read in the same cycle; otherwise flag an overrun.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (done_i && (!valid_q || rx_rd_i)) begin
            data_d  = word_i;
            valid_d = 1'b1;
            if (rx_rd_i) begin
                ovr_d = 1'b0;
            end
        end else if (done_i) begin
            ovr_d = 1'b1;
        end else if (rx_rd_i) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_data_o  = data_q;
    assign rx_valid_o = valid_q;
    assign rx_ovr_o   = ovr_q;

endmodule

// File: rtl/spi_shift.sv
// spi_shift: SPI serial datapath driven by the spi_ctrl strobes (i_load, i_en, tbuf_mosi_oe).
// Optional feature: define SPI_RX_HOLD_EN for a buffered rx_valid level with rx_rd/rx_ovr ports.
//
// Handshakes:
//   tx side: tx_wr is accepted only while tx_full is 0, or in a load cycle that empties the
//            holding register in the same cycle; a write that is not accepted is dropped.
//   rx side: default build, rx_valid is a one-cycle pulse with rx_data stable from that cycle
//            until the next completion. With SPI_RX_HOLD_EN, rx_valid stays high until rx_rd.
module spi_shift
    import spi_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_en,
    input  logic              tbuf_mosi_oe,
    input  logic [LEN_W-1:0]  xfer_len,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_wr,
    output logic              tx_full,
    output logic              tx_udr,
    input  logic              miso,
    output logic              mosi,
    output logic              mosi_oe,
`ifdef SPI_RX_HOLD_EN
    input  logic              rx_rd,
    output logic              rx_ovr,
`endif
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid
);

    strobe_e           stb;
    logic [DATA_W-1:0] mask;
    logic              accept_wr;
    logic              done;
    logic [DATA_W-1:0] rx_word;

    logic [DATA_W-1:0] hold_q, hold_d;
    logic              tx_full_q, tx_full_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              mosi_q, mosi_d;
    logic              udr_q, udr_d;
    logic [LEN_W-1:0]  wcnt_q, wcnt_d;
    logic [LEN_W-1:0]  rcnt_q, rcnt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              loaded_q, loaded_d;

    // Strobe decode, TX holding register, shift register and bit counters.
    always_comb begin
        stb       = decode_strobe(i_load, i_en, tbuf_mosi_oe);
        mask      = ~({DATA_W{1'b1}} << len_q);
        accept_wr = tx_wr && (!tx_full_q || i_load);
        done      = 1'b0;
        rx_word   = '0;
        hold_d    = hold_q;
        tx_full_d = tx_full_q;
        shreg_d   = shreg_q;
        mosi_d    = mosi_q;
        udr_d     = 1'b0;
        wcnt_d    = wcnt_q;
        rcnt_d    = rcnt_q;
        len_d     = len_q;
        loaded_d  = loaded_q;

        // The load consumes the old hold value; a same-cycle write refills the register.
        if (stb == STB_LOAD && tx_full_q) begin
            tx_full_d = 1'b0;
        end
        if (accept_wr) begin
            hold_d    = tx_data;
            tx_full_d = 1'b1;
        end

        case (stb)
            STB_LOAD: begin
                wcnt_d = '0;
                rcnt_d = '0;
                len_d  = (xfer_len == '0) ? LEN_W'(1) : xfer_len;
                if (tx_full_q) begin
                    shreg_d  = hold_q;
                    loaded_d = 1'b1;
                end
            end
            STB_WRITE: begin
                if (wcnt_q < len_q) begin
                    wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_q == '0 && !loaded_q) begin
                        // Nothing was loaded: the whole frame goes out as ones.
                        mosi_d  = 1'b1;
                        shreg_d = ({DATA_W{1'b1}} << 1) & mask;
                        udr_d   = 1'b1;
                    end else begin
                        mosi_d  = shreg_q[len_q - 1'b1];
                        shreg_d = (shreg_q << 1) & mask;
                    end
                end
            end
            STB_READ: begin
                if (rcnt_q < len_q) begin
                    rcnt_d  = rcnt_q + 1'b1;
                    shreg_d = {shreg_q[DATA_W-1:1], miso};
                    if (rcnt_d == len_q) begin
                        done     = 1'b1;
                        rx_word  = shreg_d & mask;
                        shreg_d  = '1;
                        loaded_d = 1'b0;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q    <= '0;
            tx_full_q <= 1'b0;
            shreg_q   <= '1;
            mosi_q    <= 1'b1;
            udr_q     <= 1'b0;
            wcnt_q    <= '0;
            rcnt_q    <= '0;
            len_q     <= LEN_W'(1);
            loaded_q  <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            tx_full_q <= tx_full_d;
            shreg_q   <= shreg_d;
            mosi_q    <= mosi_d;
            udr_q     <= udr_d;
            wcnt_q    <= wcnt_d;
            rcnt_q    <= rcnt_d;
            len_q     <= len_d;
            loaded_q  <= loaded_d;
        end
    end

`ifdef SPI_RX_HOLD_EN
    spi_rx_hold #(
        .DATA_W (DATA_W)
    ) u_rx_hold (
        .clk        (clk),
        .rst        (rst),
        .done_i     (done),
        .word_i     (rx_word),
        .rx_rd_i    (rx_rd),
        .rx_data_o  (rx_data),
        .rx_valid_o (rx_valid),
        .rx_ovr_o   (rx_ovr)
    );
`else
    logic [DATA_W-1:0] rx_data_q;
    logic              rx_valid_q;

    // Received word is overwritten on every completion; valid pulses for one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            if (done) begin
                rx_data_q <= rx_word;
            end
            rx_valid_q <= done;
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
`endif

    assign tx_full = tx_full_q;
    assign tx_udr  = udr_q;
    assign mosi    = mosi_q;
    assign mosi_oe = tbuf_mosi_oe;

endmodule

// File: tb/tb_spi_shift.sv
// tb_spi_shift: directed bench for spi_shift (default build, or with SPI_RX_HOLD_EN defined).
module tb_spi_shift;

    logic        clk;
    logic        rst;
    logic        i_load;
    logic        i_en;
    logic        tbuf_mosi_oe;
    logic [3:0]  xfer_len;
    logic [15:0] tx_data;
    logic        tx_wr;
    logic        tx_full;
    logic        tx_udr;
    logic        miso;
    logic        mosi;
    logic        mosi_oe;
`ifdef SPI_RX_HOLD_EN
    logic        rx_rd;
    logic        rx_ovr;
`endif
    logic [15:0] rx_data;
    logic        rx_valid;

    int n_tests = 0;
    int n_fail  = 0;

    spi_shift #(
        .DATA_W (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_load       (i_load),
        .i_en         (i_en),
        .tbuf_mosi_oe (tbuf_mosi_oe),
        .xfer_len     (xfer_len),
        .tx_data      (tx_data),
        .tx_wr        (tx_wr),
        .tx_full      (tx_full),
        .tx_udr       (tx_udr),
        .miso         (miso),
        .mosi         (mosi),
        .mosi_oe      (mosi_oe),
`ifdef SPI_RX_HOLD_EN
        .rx_rd        (rx_rd),
        .rx_ovr       (rx_ovr),
`endif
        .rx_data      (rx_data),
        .rx_valid     (rx_valid)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout required finish");
        $fatal(1);
    end

    typedef struct {
        logic [3:0]  xlen;
        logic        wr;
        logic [15:0] tx;
        logic [15:0] miso_w;
        logic        extra;
        logic [15:0] exp_mosi;
        logic [15:0] exp_rx;
        int          exp_udr;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change at a falling edge; on return the next rising edge has happened.
    task automatic tick(input logic l, input logic e, input logic o, input logic m);
        i_load       = l;
        i_en         = e;
        tbuf_mosi_oe = o;
        miso         = m;
        @(negedge clk);
    endtask

    // Write/read strobe pairs, MSB of miso_w first; collects mosi bits and pulse counts.
    task automatic pairs(input int len, input logic [15:0] miso_w, output logic [15:0] got,
                         output int udr_seen, output int early);
        got      = '0;
        udr_seen = 0;
        early    = 0;
        for (int i = 0; i < len; i++) begin
            tick(1'b0, 1'b1, 1'b1, 1'b0);
            got = {got[14:0], mosi};
            udr_seen += int'(tx_udr);
            tick(1'b0, 1'b0, 1'b1, miso_w[len-1-i]);
            udr_seen += int'(tx_udr);
            if (i < len - 1) begin
                early += int'(rx_valid);
            end
        end
    endtask

    task automatic run_xfer(input string tag, input logic [3:0] xlen, input logic wr,
                            input logic [15:0] tx, input logic [15:0] miso_w, input logic extra,
                            input logic [15:0] exp_mosi, input logic [15:0] exp_rx,
                            input int exp_udr);
        logic [15:0] got;
        int          udr_seen;
        int          early;
        int          len;
        len      = (xlen == 4'd0) ? 1 : int'(xlen);
        xfer_len = xlen;
        tx_wr    = wr;
        tx_data  = tx;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tx_wr = 1'b0;
        if (wr) begin
            check({tag, "_full_set"}, tx_full, 1);
        end
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        check({tag, "_full_clr"}, tx_full, 0);
        pairs(len, miso_w, got, udr_seen, early);
        check({tag, "_valid"}, rx_valid, 1);
        check({tag, "_rx"}, rx_data, exp_rx);
        check({tag, "_early_valid"}, early, 0);
        if (extra) begin
            tick(1'b0, 1'b1, 1'b1, 1'b0);
        end else begin
            tick(1'b0, 1'b0, 1'b0, 1'b0);
        end
`ifdef SPI_RX_HOLD_EN
        check({tag, "_valid_level"}, rx_valid, 1);
`else
        check({tag, "_valid_pulse"}, rx_valid, 0);
`endif
        check({tag, "_mosi_last"}, mosi, exp_mosi[0]);
        check({tag, "_mosi_seq"}, got, exp_mosi);
        check({tag, "_udr"}, udr_seen, exp_udr);
`ifdef SPI_RX_HOLD_EN
        rx_rd = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        rx_rd = 1'b0;
        check({tag, "_valid_clr"}, rx_valid, 0);
`endif
    endtask

    initial begin
        logic [15:0] got;
        int          udr_seen;
        int          early;
        int          vcnt;

        //                 xlen   wr    tx        miso_w    extra mosi      rx        udr
        vecs[0] = '{4'd8,  1'b1, 16'h00A5, 16'h003C, 1'b0, 16'h00A5, 16'h003C, 0};
        vecs[1] = '{4'd15, 1'b1, 16'h7FFE, 16'hFFFF, 1'b1, 16'h7FFE, 16'h7FFF, 0};
        vecs[2] = '{4'd4,  1'b0, 16'h0000, 16'h000A, 1'b0, 16'h000F, 16'h000A, 1};
        vecs[3] = '{4'd0,  1'b1, 16'h0001, 16'h0001, 1'b0, 16'h0001, 16'h0001, 0};
        vecs[4] = '{4'd0,  1'b1, 16'hFFFE, 16'h0000, 1'b0, 16'h0000, 16'h0000, 0};
        vecs[5] = '{4'd12, 1'b1, 16'h0ABC, 16'h0F0F, 1'b0, 16'h0ABC, 16'h0F0F, 0};

        rst          = 1'b0;
        i_load       = 1'b0;
        i_en         = 1'b0;
        tbuf_mosi_oe = 1'b0;
        miso         = 1'b0;
        xfer_len     = 4'd8;
        tx_data      = '0;
        tx_wr        = 1'b0;
`ifdef SPI_RX_HOLD_EN
        rx_rd        = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Reset state and mosi_oe pass-through.
        check("rst_mosi", mosi, 1);
        check("rst_tx_full", tx_full, 0);
        check("rst_tx_udr", tx_udr, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
`ifdef SPI_RX_HOLD_EN
        check("rst_rx_ovr", rx_ovr, 0);
`endif
        tbuf_mosi_oe = 1'b1;
        #1;
        check("mosi_oe_hi", mosi_oe, 1);
        tbuf_mosi_oe = 1'b0;
        #1;
        check("mosi_oe_lo", mosi_oe, 0);
        @(negedge clk);

        // Table-driven transfers.
        for (int v = 0; v < 6; v++) begin
            run_xfer($sformatf("vec%0d", v), vecs[v].xlen, vecs[v].wr, vecs[v].tx,
                     vecs[v].miso_w, vecs[v].extra, vecs[v].exp_mosi, vecs[v].exp_rx,
                     vecs[v].exp_udr);
        end

        // Write while full is dropped; write during a consuming load refills the register.
        xfer_len = 4'd8;
        tx_wr    = 1'b1;
        tx_data  = 16'h1234;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check("hold_full_set", tx_full, 1);
        tx_data = 16'h5678;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check("hold_ignore_full", tx_full, 1);
        tx_data = 16'h005A;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tx_wr = 1'b0;
        check("hold_refill_full", tx_full, 1);
        pairs(8, 16'h0000, got, udr_seen, early);
        check("hold_old_word_mosi", got, 16'h0034);
        check("hold_old_word_rx", rx_data, 16'h0000);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
`ifdef SPI_RX_HOLD_EN
        rx_rd = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        rx_rd = 1'b0;
`endif
        run_xfer("hold_new_word", 4'd8, 1'b0, 16'h0000, 16'h00C3, 1'b0, 16'h005A, 16'h00C3, 0);

        // Abort at bit 3: no completion, counters restart, shift register keeps its content.
        xfer_len = 4'd8;
        tx_wr    = 1'b1;
        tx_data  = 16'h00A5;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tx_wr = 1'b0;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        pairs(3, 16'h0001, got, udr_seen, early);
        check("abort_partial_mosi", got, 16'h0005);
        vcnt = 0;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        vcnt += int'(rx_valid);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            vcnt += int'(rx_valid);
        end
        check("abort_no_valid", vcnt, 0);
        run_xfer("after_abort", 4'd8, 1'b0, 16'h0000, 16'h0096, 1'b0, 16'h0029, 16'h0096, 0);

        // Asynchronous reset in the middle of a transfer.
        xfer_len = 4'd8;
        tx_wr    = 1'b1;
        tx_data  = 16'h00A5;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tx_wr = 1'b0;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        check("pre_rst_mosi", mosi, 0);
        tx_wr   = 1'b1;
        tx_data = 16'hFFFF;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tx_wr = 1'b0;
        check("pre_rst_full", tx_full, 1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_mosi", mosi, 1);
        check("async_rst_full", tx_full, 0);
        check("async_rst_udr", tx_udr, 0);
        check("async_rst_rx_data", rx_data, 0);
        check("async_rst_rx_valid", rx_valid, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_xfer("post_rst_udr", 4'd4, 1'b0, 16'h0000, 16'h0005, 1'b0, 16'h000F, 16'h0005, 1);

`ifdef SPI_RX_HOLD_EN
        // Overrun: second completion without a read keeps the first word.
        xfer_len = 4'd8;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        pairs(8, 16'h0011, got, udr_seen, early);
        check("ovr_first_valid", rx_valid, 1);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        pairs(8, 16'h0022, got, udr_seen, early);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check("ovr_rx_data", rx_data, 16'h0011);
        check("ovr_flag", rx_ovr, 1);
        check("ovr_valid_held", rx_valid, 1);
        rx_rd = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        rx_rd = 1'b0;
        check("ovr_rd_valid_clr", rx_valid, 0);
        check("ovr_rd_flag_clr", rx_ovr, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
